// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline sequencing controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_e;

  localparam int unsigned MUL_LATENCY_DEF  = 3;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - 32-bit wrapping event counter with enable and synchronous clear
module perf_counter (
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  output logic [31:0] count
);

  // clear has priority over counting; the count wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/bubble sequencing for the 5-stage pipeline
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY  = MUL_LATENCY_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz_stall,
  input  logic        id_valid_inst,
  input  logic        id_mul,
  input  logic        id_halt,
  input  logic        ex_take_branch,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        mul_busy,
  output logic        halted,
  output logic [31:0] stall_cycles
);

  // Counter preloads; a single-cycle multiply never enters MUL_WAIT, so its preload is unused.
  localparam logic [3:0] MUL_CNT_INIT   = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;
  localparam logic [3:0] DRAIN_CNT_INIT = 4'(DRAIN_CYCLES - 1);

  pipe_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_en;

  // State and countdown registers; reset aborts any multiply wait or drain in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-stage enables; reset forces a safe flushed/bubbled pipeline
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_busy      = (state_q == MUL_WAIT);
    halted        = (state_q == HALTED);

    case (state_q)
      RUN: begin
        if (ex_take_branch) begin
          // wrong-path instructions in IF/ID and ID are squashed; PC takes the target
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (id_halt) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = DRAIN;
          cnt_d        = DRAIN_CNT_INIT;
        end else if (hz_stall) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (id_mul && id_valid_inst) begin
          if (MUL_LATENCY > 1) begin
            state_d = MUL_WAIT;
            cnt_d   = MUL_CNT_INIT;
          end
        end
      end

      MUL_WAIT: begin
        // the multiply owns EX, so nothing upstream may move
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DRAIN: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        if (ex_take_branch) begin
          // an older branch proves the halt was speculative: resume at the target
          if_id_flush = 1'b1;
          pc_en       = 1'b1;
          state_d     = RUN;
        end else if (cnt_q == 4'd0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      HALTED: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_bubble  = 1'b1;
        ex_mem_bubble = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mul_busy      = 1'b0;
      halted        = 1'b0;
    end
  end

  assign stall_en = !pc_en && (state_q != HALTED);

  perf_counter u_stall_counter (
    .clk   (clk),
    .clear (rst),
    .en    (stall_en),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hz_stall, id_valid_inst, id_mul, id_halt, ex_take_branch;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble;
  logic        mul_busy, halted;
  logic [31:0] stall_cycles;
  logic        pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_bubble1, ex_mem_bubble1;
  logic        mul_busy1, halted1;
  logic [31:0] stall_cycles1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MUL_LATENCY(3), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .id_valid_inst(id_valid_inst),
    .id_mul(id_mul), .id_halt(id_halt), .ex_take_branch(ex_take_branch),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .mul_busy(mul_busy),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.MUL_LATENCY(1), .DRAIN_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .id_valid_inst(id_valid_inst),
    .id_mul(id_mul), .id_halt(id_halt), .ex_take_branch(ex_take_branch),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1), .id_ex_en(id_ex_en1),
    .id_ex_bubble(id_ex_bubble1), .ex_mem_bubble(ex_mem_bubble1), .mul_busy(mul_busy1),
    .halted(halted1), .stall_cycles(stall_cycles1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // inputs change 1ns after the rising edge, outputs are sampled 1ns later
  task automatic drive(input logic hz, input logic vi, input logic mul,
                       input logic hlt, input logic br);
    hz_stall       = hz;
    id_valid_inst  = vi;
    id_mul         = mul;
    id_halt        = hlt;
    ex_take_branch = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_en"}, {31'd0, pc_en}, 32'd0);
    check({tag, "_if_id_en"}, {31'd0, if_id_en}, 32'd0);
    check({tag, "_id_ex_en"}, {31'd0, id_ex_en}, 32'd1);
    check({tag, "_id_ex_bubble"}, {31'd0, id_ex_bubble}, 32'd1);
    check({tag, "_ex_mem_bubble"}, {31'd0, ex_mem_bubble}, 32'd1);
    check({tag, "_if_id_flush"}, {31'd0, if_id_flush}, 32'd1);
    check({tag, "_mul_busy"}, {31'd0, mul_busy}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic check_after_reset(input string tag);
    check({tag, "_state_run_mul_busy"}, {31'd0, mul_busy}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    check({tag, "_pc_en"}, {31'd0, pc_en}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    #1;
    check("reset_stall_cycles", stall_cycles, 32'd0);

    // idle RUN
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0);
      check("idle_pc_en", {31'd0, pc_en}, 32'd1);
      check("idle_if_id_en", {31'd0, if_id_en}, 32'd1);
      check("idle_id_ex_bubble", {31'd0, id_ex_bubble}, 32'd0);
      tick();
    end
    check("idle_stall_cycles", stall_cycles, 32'd0);

    // three single-cycle load-use stalls
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      check("hz_pc_en", {31'd0, pc_en}, 32'd0);
      check("hz_id_ex_bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick();
      drive(0, 1, 0, 0, 0);
      check("hz_release_pc_en", {31'd0, pc_en}, 32'd1);
      tick();
    end
    check("hz_stall_cycles", stall_cycles, 32'd3);

    // multiply, latency 3 (dut) and latency 1 (dut1)
    drive(0, 1, 1, 0, 0);
    check("mul_issue_pc_en", {31'd0, pc_en}, 32'd1);
    check("mul_issue_busy", {31'd0, mul_busy}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check("mul_busy", {31'd0, mul_busy}, 32'd1);
      check("mul_ex_mem_bubble", {31'd0, ex_mem_bubble}, 32'd1);
      check("mul_pc_en", {31'd0, pc_en}, 32'd0);
      check("mul_id_ex_en", {31'd0, id_ex_en}, 32'd0);
      check("mul1_busy", {31'd0, mul_busy1}, 32'd0);
      tick();
    end
    check("mul_done_busy", {31'd0, mul_busy}, 32'd0);
    check("mul_done_pc_en", {31'd0, pc_en}, 32'd1);
    check("mul_stall_cycles", stall_cycles, 32'd5);
    check("mul1_stall_cycles", stall_cycles1, 32'd3);

    // branch together with multiply: branch wins
    drive(0, 1, 1, 0, 1);
    check("br_mul_flush", {31'd0, if_id_flush}, 32'd1);
    check("br_mul_bubble", {31'd0, id_ex_bubble}, 32'd1);
    check("br_mul_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("br_mul_next_busy", {31'd0, mul_busy}, 32'd0);
    check("br_mul_stall_cycles", stall_cycles, 32'd5);

    // stall together with multiply: stall wins, multiply issues next cycle
    drive(1, 1, 1, 0, 0);
    check("hz_mul_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    drive(0, 1, 1, 0, 0);
    check("hz_mul_next_busy", {31'd0, mul_busy}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 1);
    check("mulwait_br_busy", {31'd0, mul_busy}, 32'd1);
    check("mulwait_br_ignored_flush", {31'd0, if_id_flush}, 32'd0);
    check("mulwait_br_ignored_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("mulwait2_busy", {31'd0, mul_busy}, 32'd1);
    tick();
    check("hz_mul_done_busy", {31'd0, mul_busy}, 32'd0);
    check("hz_mul_stall_cycles", stall_cycles, 32'd8);

    // halt, DRAIN_CYCLES=3
    drive(0, 0, 0, 1, 0);
    check("halt_pc_en", {31'd0, pc_en}, 32'd0);
    check("halt_bubble", {31'd0, id_ex_bubble}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("drain_halted", {31'd0, halted}, 32'd0);
      check("drain_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    check("halted_rise", {31'd0, halted}, 32'd1);
    check("halted_pc_en", {31'd0, pc_en}, 32'd0);
    check("halted_id_ex_en", {31'd0, id_ex_en}, 32'd0);
    check("halted_stall_cycles", stall_cycles, 32'd12);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1, 1);
      check("halted_hold", {31'd0, halted}, 32'd1);
      check("halted_hold_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    check("halted_stall_frozen", stall_cycles, 32'd12);

    // reset out of HALTED
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    check_reset_outputs("rst_halted");
    tick();
    rst = 1'b0;
    #1;
    check_after_reset("rst_halted");

    // halt cancelled by a branch in the 2nd DRAIN cycle
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    check("drain_br_flush", {31'd0, if_id_flush}, 32'd1);
    check("drain_br_pc_en", {31'd0, pc_en}, 32'd1);
    check("drain_br_halted", {31'd0, halted}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("cancel_halted", {31'd0, halted}, 32'd0);
      check("cancel_pc_en", {31'd0, pc_en}, 32'd1);
      tick();
    end
    check("cancel_stall_cycles", stall_cycles, 32'd2);

    // reset during MUL_WAIT
    drive(0, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("pre_rst_mul_busy", {31'd0, mul_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mul_busy_forced", {31'd0, mul_busy}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_after_reset("rst_mulwait");
    tick();
    check("rst_mulwait_stays_run", {31'd0, mul_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
